// File: rtl/nto1_mbit_arb_mux_if.sv
// ============================================================================
// Module   : nto1_mbit_arb_mux_if
// Brief    : Handshake bundle for the N-to-1 arbitrated stream multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nto1_mbit_arb_mux_if #(
    parameter int N = 16,
    parameter int M = 32
);
    localparam int c_CW = $clog2(N);

    logic [N*M-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_ready;
    logic [M-1:0]    out_data;
    logic            out_valid;
    logic            out_last;
    logic [c_CW-1:0] out_chan;
    logic            out_ready;
    logic            locked;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_chan, locked
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_chan, locked
    );
endinterface

`default_nettype wire

// File: rtl/nto1_mbit_arb_mux.sv
// ============================================================================
// Module   : nto1_mbit_arb_mux
// Brief    : N-to-1 M-bit stream mux with internal RR/fixed-priority arbiter,
//            optional packet lock, and one registered output stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nto1_mbit_arb_mux #(
    parameter int N            = 16,
    parameter int M            = 32,
    parameter int MODE         = 0,
    parameter int LOCK_ON_LAST = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    nto1_mbit_arb_mux_if.slave    bus
);
    localparam int               c_CW     = $clog2(N);
    localparam logic [c_CW:0]    c_N_EXT  = (c_CW+1)'(N);
    localparam logic [c_CW-1:0]  c_LAST_CH = c_CW'(N-1);
    localparam logic [0:0]       c_IDLE   = 1'b0;
    localparam logic [0:0]       c_LOCKED = 1'b1;

    logic [0:0]      r_state;
    logic [c_CW-1:0] r_lock_chan;
    logic [c_CW-1:0] r_ptr;
    logic            r_out_valid;
    logic [M-1:0]    r_out_data;
    logic            r_out_last;
    logic [c_CW-1:0] r_out_chan;

    logic [N-1:0]    w_rot;
    logic [c_CW-1:0] w_off;
    logic [c_CW:0]   w_sum;
    logic [c_CW-1:0] w_grant;
    logic            w_grant_valid;
    logic            w_load;
    logic            w_xfer;
    logic [M-1:0]    w_gdata;
    logic            w_glast;
    logic [N-1:0]    w_in_ready;

    assign w_load = !r_out_valid || bus.out_ready;

    // Round-robin: rotate valids so ptr sits at bit 0, take the first set bit,
    // then map the offset back to an absolute channel index.
    always_comb begin
        w_rot = N'({bus.in_valid, bus.in_valid} >> r_ptr);
        w_off = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (w_rot[k]) w_off = c_CW'(k);
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= c_N_EXT) w_sum = w_sum - c_N_EXT;
    end

    always_comb begin
        w_grant       = '0;
        w_grant_valid = 1'b0;
        if (r_state == c_LOCKED) begin
            w_grant       = r_lock_chan;
            w_grant_valid = bus.in_valid[r_lock_chan];
        end else if (MODE == 1) begin
            for (int i = N-1; i >= 0; i--) begin
                if (bus.in_valid[i]) w_grant = c_CW'(i);
            end
            w_grant_valid = |bus.in_valid;
        end else begin
            w_grant       = w_sum[c_CW-1:0];
            w_grant_valid = |bus.in_valid;
        end
    end

    assign w_xfer  = rst_n && w_load && w_grant_valid;
    assign w_glast = bus.in_last[w_grant];

    always_comb begin
        w_gdata    = '0;
        w_in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == c_CW'(i)) begin
                w_gdata       = bus.in_data[i*M +: M];
                w_in_ready[i] = w_xfer;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_chan  <= '0;
            r_state     <= c_IDLE;
            r_lock_chan <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gdata;
                r_out_last  <= w_glast;
                r_out_chan  <= w_grant;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_xfer && LOCK_ON_LAST != 0) begin
                if (r_state == c_IDLE) begin
                    if (!w_glast) begin
                        r_state     <= c_LOCKED;
                        r_lock_chan <= w_grant;
                    end
                end else if (w_glast) begin
                    r_state <= c_IDLE;
                end
            end

            // Pointer only advances when arbitration actually ends.
            if (w_xfer && (w_glast || LOCK_ON_LAST == 0)) begin
                if (w_grant == c_LAST_CH) r_ptr <= '0;
                else                      r_ptr <= w_grant + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_chan  = r_out_chan;
    assign bus.locked    = (r_state == c_LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_nto1_mbit_arb_mux.sv
// ============================================================================
// Module   : tb_nto1_mbit_arb_mux
// Brief    : Bench for nto1_mbit_arb_mux; three configurations share stimulus
//            and are each tracked by a behavioural model plus a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nto1_mbit_arb_mux;
    localparam int N = 4;
    localparam int M = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [N*M-1:0] s_data  = '0;
    logic [N-1:0]   s_valid = '0;
    logic [N-1:0]   s_last  = '0;
    logic           s_oready = 1'b0;

    always #5 clk = ~clk;

    nto1_mbit_arb_mux_if #(.N(N), .M(M)) bus0 ();
    nto1_mbit_arb_mux_if #(.N(N), .M(M)) bus1 ();
    nto1_mbit_arb_mux_if #(.N(N), .M(M)) bus2 ();

    assign bus0.in_data = s_data;  assign bus0.in_valid = s_valid;
    assign bus0.in_last = s_last;  assign bus0.out_ready = s_oready;
    assign bus1.in_data = s_data;  assign bus1.in_valid = s_valid;
    assign bus1.in_last = s_last;  assign bus1.out_ready = s_oready;
    assign bus2.in_data = s_data;  assign bus2.in_valid = s_valid;
    assign bus2.in_last = s_last;  assign bus2.out_ready = s_oready;

    nto1_mbit_arb_mux #(.N(N), .M(M), .MODE(0), .LOCK_ON_LAST(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    nto1_mbit_arb_mux #(.N(N), .M(M), .MODE(0), .LOCK_ON_LAST(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    nto1_mbit_arb_mux #(.N(N), .M(M), .MODE(1), .LOCK_ON_LAST(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int c_mode [3] = '{0, 0, 1};
    int c_lol  [3] = '{0, 1, 1};

    int n_cmp  = 0;
    int n_fail = 0;

    // Model of each configuration: packet owner (-1 = none), RR pointer, output register.
    int         m_owner [3];
    int         m_ptr   [3];
    logic       m_ov    [3];
    logic       m_ol    [3];
    logic [7:0] m_od    [3];
    logic [1:0] m_oc    [3];

    logic [3:0] o_ir [3];
    logic       o_ov [3];
    logic       o_ol [3];
    logic       o_lk [3];
    logic [7:0] o_od [3];
    logic [1:0] o_oc [3];
    bit         xf   [3];
    int         xg   [3];

    // Producers: per-channel beat buffers {last, data}; scoreboard {chan, last, data}.
    logic [8:0]  pbuf [N][128];
    int          ph [N];
    int          pt [N];
    bit          held [N];
    bit          off  [N];
    logic [10:0] sb [$];
    int          cap [$];
    int          drv = 0;
    int          rdy_pct = 100;
    int          gate_pct = 100;

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_owner[d] = -1; m_ptr[d] = 0;
            m_ov[d] = 1'b0; m_ol[d] = 1'b0; m_od[d] = '0; m_oc[d] = '0;
        end
    endtask

    task automatic get_obs(input int d);
        case (d)
            0: begin o_ir[0] = bus0.in_ready; o_ov[0] = bus0.out_valid; o_od[0] = bus0.out_data;
                     o_ol[0] = bus0.out_last; o_oc[0] = bus0.out_chan;  o_lk[0] = bus0.locked; end
            1: begin o_ir[1] = bus1.in_ready; o_ov[1] = bus1.out_valid; o_od[1] = bus1.out_data;
                     o_ol[1] = bus1.out_last; o_oc[1] = bus1.out_chan;  o_lk[1] = bus1.locked; end
            default: begin o_ir[2] = bus2.in_ready; o_ov[2] = bus2.out_valid; o_od[2] = bus2.out_data;
                     o_ol[2] = bus2.out_last; o_oc[2] = bus2.out_chan;  o_lk[2] = bus2.locked; end
        endcase
    endtask

    task automatic step();
        #1;
        for (int d = 0; d < 3; d++) begin
            int g; bit gv; bit ld; logic [3:0] er;
            get_obs(d);
            ld = !m_ov[d] || s_oready;
            g = 0; gv = 1'b0;
            if (m_owner[d] >= 0) begin
                g = m_owner[d]; gv = s_valid[g];
            end else begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (c_mode[d] == 1) ? k : (m_ptr[d] + k) % N;
                    if (!gv && s_valid[c]) begin g = c; gv = 1'b1; end
                end
            end
            er = '0;
            if (rst_n && ld && gv) er[g] = 1'b1;
            n_cmp++; if (o_ir[d] !== er) begin n_fail++;
                $display("FAIL in_ready dut%0d t=%0t got %b want %b", d, $time, o_ir[d], er); end
            n_cmp++; if (o_ov[d] !== m_ov[d]) begin n_fail++;
                $display("FAIL out_valid dut%0d t=%0t got %b want %b", d, $time, o_ov[d], m_ov[d]); end
            n_cmp++; if (o_od[d] !== m_od[d]) begin n_fail++;
                $display("FAIL out_data dut%0d t=%0t got %h want %h", d, $time, o_od[d], m_od[d]); end
            n_cmp++; if (o_ol[d] !== m_ol[d]) begin n_fail++;
                $display("FAIL out_last dut%0d t=%0t got %b want %b", d, $time, o_ol[d], m_ol[d]); end
            n_cmp++; if (o_oc[d] !== m_oc[d]) begin n_fail++;
                $display("FAIL out_chan dut%0d t=%0t got %0d want %0d", d, $time, o_oc[d], m_oc[d]); end
            n_cmp++; if (o_lk[d] !== (m_owner[d] >= 0)) begin n_fail++;
                $display("FAIL locked dut%0d t=%0t got %b want %b", d, $time, o_lk[d], m_owner[d] >= 0); end
            xf[d] = rst_n && ld && gv;
            xg[d] = g;
        end
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (xf[d]) begin
                    int g;
                    g = xg[d];
                    m_ov[d] = 1'b1; m_od[d] = s_data[g*M +: M]; m_ol[d] = s_last[g]; m_oc[d] = 2'(g);
                    if (c_lol[d] == 1) m_owner[d] = s_last[g] ? -1 : g;
                    if (s_last[g] || c_lol[d] == 0) m_ptr[d] = (g + 1) % N;
                end else if (s_oready) begin
                    m_ov[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic cycle();
        logic [10:0] exp_b, got_b;
        @(negedge clk);
        s_oready = ($urandom_range(99) < rdy_pct);
        for (int c = 0; c < N; c++) begin
            if (ph[c] != pt[c] && !off[c] && (held[c] || $urandom_range(99) < gate_pct)) begin
                s_valid[c] = 1'b1;
                s_data[c*M +: M] = pbuf[c][ph[c]][7:0];
                s_last[c] = pbuf[c][ph[c]][8];
            end else begin
                s_valid[c] = 1'b0;
                s_data[c*M +: M] = '0;
                s_last[c] = 1'b0;
            end
        end
        step();
        if (rst_n && o_ov[drv] && s_oready) begin
            got_b = {o_oc[drv], o_ol[drv], o_od[drv]};
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard dut%0d t=%0t got extra beat %h want none", drv, $time, got_b);
            end else begin
                exp_b = sb.pop_front();
                if (got_b !== exp_b) begin
                    n_fail++;
                    $display("FAIL scoreboard dut%0d t=%0t got %h want %h", drv, $time, got_b, exp_b);
                end
            end
            cap.push_back(int'(o_oc[drv]));
        end
        if (rst_n && xf[drv]) begin
            int c;
            c = xg[drv];
            sb.push_back({2'(c), pbuf[c][ph[c]]});
            ph[c]++;
        end
        for (int c = 0; c < N; c++) held[c] = s_valid[c] && !(xf[drv] && xg[drv] == c);
        if (!rst_n) begin
            sb.delete();
            for (int c = 0; c < N; c++) held[c] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic add_pkt(input int c, input int nb, input int base);
        for (int b = 0; b < nb; b++) begin
            pbuf[c][pt[c]] = {(b == nb-1), 8'(base + b)};
            pt[c]++;
        end
    endtask

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int c = 0; c < N; c++) if (ph[c] != pt[c]) e = 1'b0;
        return e;
    endfunction

    task automatic do_reset();
        for (int c = 0; c < N; c++) begin ph[c] = 0; pt[c] = 0; held[c] = 1'b0; off[c] = 1'b0; end
        sb.delete(); cap.delete();
        rdy_pct = 100; gate_pct = 100;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        rdy_pct = 100; gate_pct = 100;
        for (int c = 0; c < N; c++) off[c] = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (all_empty() && sb.size() == 0) break;
            cycle();
        end
        n_cmp++;
        if (!(all_empty() && sb.size() == 0)) begin
            n_fail++;
            $display("FAIL drain dut%0d got %0d beats in flight want 0", drv, sb.size());
        end
    endtask

    task automatic check_cap(input string nm, input int idx, input int want);
        n_cmp++;
        if (idx >= cap.size()) begin
            n_fail++; $display("FAIL %s beat%0d got none want chan %0d", nm, idx, want);
        end else if (cap[idx] != want) begin
            n_fail++; $display("FAIL %s beat%0d got chan %0d want chan %0d", nm, idx, cap[idx], want);
        end
    endtask

    task automatic test_reset();
        drv = 1;
        for (int c = 0; c < N; c++) add_pkt(c, 1, 8'h50 + c);
        rst_n = 1'b0;
        cycle();
        cycle();
        n_cmp++; if (o_ir[1] !== 4'b0000) begin n_fail++;
            $display("FAIL reset_in_ready got %b want 0000", o_ir[1]); end
        n_cmp++; if (o_ov[1] !== 1'b0 || o_lk[1] !== 1'b0) begin n_fail++;
            $display("FAIL reset_state got valid=%b locked=%b want 0 0", o_ov[1], o_lk[1]); end
        do_reset();
    endtask

    task automatic test_rr_stream();
        do_reset();
        drv = 0;
        for (int c = 0; c < N; c++) for (int b = 0; b < 8; b++) add_pkt(c, 1, 8'h10 + c);
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (k == 0) begin
                n_cmp++; if (o_ov[0] !== 1'b0) begin n_fail++;
                    $display("FAIL rr_first_valid got %b want 0", o_ov[0]); end
            end else begin
                n_cmp++; if (o_ov[0] !== 1'b1 || o_oc[0] !== 2'((k-1) % 4) || o_od[0] !== 8'(8'h10 + (k-1) % 4)) begin
                    n_fail++;
                    $display("FAIL rr_seq cyc%0d got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                             k, o_ov[0], o_oc[0], o_od[0], (k-1) % 4, 8'h10 + (k-1) % 4);
                end
            end
        end
        drain();
    endtask

    task automatic test_lock_packet();
        do_reset();
        drv = 1;
        add_pkt(1, 1, 8'h21);
        cycle(); cycle(); cycle();
        cap.delete();
        for (int b = 0; b < 3; b++) begin add_pkt(0, 1, 8'hA0 + b); add_pkt(1, 1, 8'hB0 + b); end
        add_pkt(2, 3, 8'hC0);
        drain();
        check_cap("lock_seq", 0, 2);
        check_cap("lock_seq", 1, 2);
        check_cap("lock_seq", 2, 2);
        check_cap("lock_seq", 3, 0);
    endtask

    task automatic test_backpressure();
        do_reset();
        drv = 1;
        for (int b = 0; b < 4; b++) add_pkt(1, 1, 8'h31 + b);
        rdy_pct = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (k >= 1) begin
                n_cmp++; if (o_ov[1] !== 1'b1 || o_od[1] !== 8'h31 || o_ir[1] !== 4'b0000) begin n_fail++;
                    $display("FAIL bp_hold cyc%0d got v=%b d=%h rdy=%b want v=1 d=31 rdy=0000",
                             k, o_ov[1], o_od[1], o_ir[1]); end
            end
        end
        drain();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        drv = 2;
        for (int b = 0; b < 3; b++) add_pkt(1, 1, 8'h41 + b);
        for (int b = 0; b < 2; b++) add_pkt(3, 1, 8'h43 + b);
        drain();
        check_cap("prio_seq", 0, 1);
        check_cap("prio_seq", 2, 1);
        check_cap("prio_seq", 3, 3);
        check_cap("prio_seq", 4, 3);
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        drv = 1;
        add_pkt(0, 4, 8'h60);
        add_pkt(1, 1, 8'h70);
        cycle(); cycle();
        rst_n = 1'b0;
        pt[0] = ph[0];
        cycle();
        rst_n = 1'b1;
        cycle();
        n_cmp++; if (o_ir[1] !== 4'b0010 || o_ov[1] !== 1'b0 || o_lk[1] !== 1'b0) begin n_fail++;
            $display("FAIL reset_mid got rdy=%b v=%b lk=%b want 0010 0 0", o_ir[1], o_ov[1], o_lk[1]); end
        drain();
    endtask

    task automatic test_gapped_lock();
        do_reset();
        drv = 1;
        add_pkt(2, 4, 8'h80);
        for (int b = 0; b < 3; b++) add_pkt(0, 1, 8'h90 + b);
        off[0] = 1'b1;
        cycle();
        off[0] = 1'b0; off[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_cmp++; if (o_ir[1] !== 4'b0000 || o_lk[1] !== 1'b1) begin n_fail++;
                $display("FAIL gap_hold cyc%0d got rdy=%b lk=%b want 0000 1", k, o_ir[1], o_lk[1]); end
        end
        drain();
        for (int i = 0; i < 4; i++) check_cap("gap_seq", i, 2);
        check_cap("gap_seq", 4, 0);
    endtask

    task automatic test_random();
        for (int d = 0; d < 3; d++) begin
            do_reset();
            drv = d;
            for (int c = 0; c < N; c++)
                for (int p = 0; p < 6; p++) add_pkt(c, $urandom_range(1, 4), $urandom_range(0, 255));
            rdy_pct = 70; gate_pct = 60;
            for (int k = 0; k < 300; k++) cycle();
            drain();
        end
    endtask

    initial begin
        model_reset();
        for (int c = 0; c < N; c++) begin ph[c] = 0; pt[c] = 0; held[c] = 1'b0; off[c] = 1'b0; end
        @(posedge clk);
        #1;
        test_reset();
        test_rr_stream();
        test_lock_packet();
        test_backpressure();
        test_fixed_priority();
        test_reset_mid_packet();
        test_gapped_lock();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
